issue_scheduler: RTL

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/issue_scheduler.sv
// issue_scheduler: dual-issue front end. Fetched instruction pairs go into a
// circular queue. Each unstalled cycle the scheduler issues the head pair, or
// only the head instruction when the two depend on each other.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   fetch_valid, instr1/2   incoming pair (instr1 older), fetch_ready = room for a pair
//   flush                   drop queued and issued instructions
//   stall                   hold the current issue group, no pop
//   issue0_*/issue1_*       issue slots (slot 0 older)
//   issue_single, hazard    group size / dependency-reduced indication
//   q_count                 queue occupancy
module issue_scheduler #(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_valid,
  input  logic [15:0]                  instr1,
  input  logic [15:0]                  instr2,
  output logic                         fetch_ready,
  input  logic                         flush,
  input  logic                         stall,
  output logic                         issue0_valid,
  output logic [15:0]                  issue0_instr,
  output logic                         issue1_valid,
  output logic [15:0]                  issue1_instr,
  output logic                         issue_single,
  output logic                         hazard,
  output logic [$clog2(QDEPTH+1)-1:0]  q_count
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [15:0]   mem [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  logic [15:0]   h0;
  logic [15:0]   h1;
  logic          dep;
  logic          push;
  logic [1:0]    pop_n;
  logic [CW-1:0] count_next;

  // Pointer advance modulo QDEPTH (QDEPTH need not be a power of two).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= QDEPTH) s = s - QDEPTH;
    return PW'(s);
  endfunction

  // Dependency check between the two oldest queued instructions.
  always_comb begin
    h0  = mem[head];
    h1  = mem[ptr_add(head, 1)];
    dep = (h0[10:8] == h1[10:8]) ||
          (h0[10:8] == h1[7:5])  ||
          (!h1[11] && (h0[10:8] == h1[4:2])) ||
          (h1[10:8] == h0[7:5])  ||
          (!h0[11] && (h1[10:8] == h0[4:2]));
  end

  // Push/pop decisions and next occupancy; fetch_ready ignores same-cycle pops.
  always_comb begin
    push  = 1'b0;
    pop_n = 2'd0;
    push  = rst_n && !flush && fetch_valid && fetch_ready;
    if (rst_n && !flush && !stall) begin
      if (q_count == CW'(0))      pop_n = 2'd0;
      else if (q_count == CW'(1)) pop_n = 2'd1;
      else if (dep)               pop_n = 2'd1;
      else                        pop_n = 2'd2;
    end
    count_next = q_count + (push ? CW'(2) : CW'(0)) - CW'(pop_n);
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail]             <= instr1;
      mem[ptr_add(tail, 1)] <= instr2;
    end
  end

  // Pointers, occupancy and issue registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      q_count      <= '0;
      fetch_ready  <= 1'b1;
      issue0_valid <= 1'b0;
      issue1_valid <= 1'b0;
      issue_single <= 1'b0;
      hazard       <= 1'b0;
      issue0_instr <= 16'h0000;
      issue1_instr <= 16'h0000;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      q_count      <= '0;
      fetch_ready  <= 1'b1;
      issue0_valid <= 1'b0;
      issue1_valid <= 1'b0;
      issue_single <= 1'b0;
      hazard       <= 1'b0;
    end else begin
      if (push) tail <= ptr_add(tail, 2);
      head        <= ptr_add(head, 32'(pop_n));
      q_count     <= count_next;
      fetch_ready <= (count_next <= CW'(QDEPTH - 2));
      if (!stall) begin
        if (q_count == CW'(0)) begin
          issue0_valid <= 1'b0;
          issue1_valid <= 1'b0;
          issue_single <= 1'b0;
          hazard       <= 1'b0;
        end else if (q_count == CW'(1) || dep) begin
          issue0_valid <= 1'b1;
          issue0_instr <= h0;
          issue1_valid <= 1'b0;
          issue_single <= 1'b1;
          hazard       <= (q_count != CW'(1));
        end else begin
          issue0_valid <= 1'b1;
          issue0_instr <= h0;
          issue1_valid <= 1'b1;
          issue1_instr <= h1;
          issue_single <= 1'b0;
          hazard       <= 1'b0;
        end
      end
    end
  end

endmodule
